param_updown_counter: RTL
=========================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter with programmable upper bound, synchronous load,
//   enable, start/stop control and free-run or one-shot mode. Generic timing and
//   sequencing primitive for blocks that need bounded wrap/terminal-count events.
// PARAMETERS
//   WIDTH      4              count width in bits (>=2)
//   MAX_VAL    2**WIDTH-1     upper bound; count range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
//   RESET_VAL  0              count value after reset and on restart from DONE (<= MAX_VAL)
// PORTS
//   clk       in   1      clock, rising edge
//   reset_n   in   1      asynchronous reset, active low
//   en        in   1      count enable, steps only when in RUN
//   updown    in   1      1 = count up, 0 = count down
//   oneshot   in   1      0 = free-run, 1 = stop at first boundary
//   start     in   1      IDLE->RUN; DONE->RUN with count reloaded to RESET_VAL
//   stop      in   1      RUN/DONE -> IDLE
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  load value; values > MAX_VAL clip to MAX_VAL
//   count     out  WIDTH  current count, registered
//   tc        out  1      terminal-count pulse, registered
//   busy      out  1      state == RUN
//   done      out  1      state == DONE
// BEHAVIOUR
//   Reset (async, any time, including mid-count): count=RESET_VAL, tc=0, state=IDLE
//     (busy=0, done=0). Outputs take effect immediately on reset_n falling.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: count holds. start=1 -> RUN.
//     RUN: stop=1 -> IDLE. One-shot boundary hit -> DONE (see below).
//     DONE: count holds. start=1 -> RUN, count<=RESET_VAL. stop=1 -> IDLE.
//     stop and start together: stop wins.
//   Step (RUN, en=1, load=0): up: count+1, down: count-1.
//   Boundary: up with count==MAX_VAL, or down with count==0.
//     free-run: wrap. MAX_VAL->0 up, 0->MAX_VAL down. tc=1 for exactly the cycle after the wrapping edge.
//     one-shot: count holds at the boundary, tc=1 for one cycle, state -> DONE on the same edge.
//   tc=0 in every other cycle. Not asserted by load, start or reset.
//   load: highest priority over step in every state. count<=min(load_val, MAX_VAL).
//     State is unchanged. Load together with start from DONE: load value wins over RESET_VAL.
//   en=0 or state!=RUN: count holds. updown may change any cycle and takes effect on the next step.
//   Arithmetic is in WIDTH bits. count never exceeds MAX_VAL.
//   One step per enabled cycle. Latency from input to count/tc is one clock edge.
// CONFIGURATION
//   UDC_SATURATE_EN defined: free-run mode saturates instead of wrapping.
//     An attempted boundary step leaves count held and sets tc=1 for every cycle
//     such a step is attempted (en=1, RUN).
//     One-shot behaviour is unchanged.
//   UDC_SATURATE_EN undefined: free-run wraps as above.
// STRUCTURE
//   Package udc_pkg: state encoding constants UDC_IDLE=2'd0, UDC_RUN=2'd1,
//     UDC_DONE=2'd2, and the 2-bit state typedef.
//   Sub-module udc_step: combinational next-count and boundary-detect datapath.
//     Inputs: count, updown, MAX_VAL. Outputs: next count, at_boundary.
//   The top holds the FSM, the load clip and the tc register.
// TESTING (WIDTH=4, MAX_VAL=9, RESET_VAL=0 unless stated)
//   1. Reset, start, en=1, updown=1, free-run, 12 cycles -> count 1..9,0,1,2.
//      tc=1 only in the cycle after 9->0.
//   2. load=1, load_val=3, then down, en=1 for 5 cycles -> 3,2,1,0,9,8.
//      tc pulses once after 0->9. load_val=15 -> count=9 (clip).
//   3. oneshot=1, up, from 7 -> 8, 9, then held 9; tc one pulse; done=1, busy=0.
//      start -> count=0, busy=1.
//   4. In RUN with start=stop=1 -> IDLE. en toggling -> count steps only when en=1.
//   5. reset_n low mid-count at 6 -> count=0, tc=0, busy=0 immediately.
//      Release, start -> counting resumes from 0.
//   6. With UDC_SATURATE_EN, free-run up at 9, en=1 for 3 cycles -> count stays 9,
//      tc=1 in all 3 cycles. Down at 0 behaves symmetrically.

Source files
------------

// File: rtl/udc_pkg.sv
// Shared state encoding for the parametrised up/down counter.
package udc_pkg;

  localparam int unsigned UDC_STATE_W = 2;

  typedef enum logic [UDC_STATE_W-1:0] {
    UDC_IDLE = 2'd0,
    UDC_RUN  = 2'd1,
    UDC_DONE = 2'd2
  } udc_state_t;

endpackage : udc_pkg

// File: rtl/udc_step.sv
// Combinational step datapath: next count in the current direction with
// wrap at 0/MAX_VAL, plus a flag marking that this step crosses the bound.
module udc_step #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             updown,
  output logic [WIDTH-1:0] next_count,
  output logic             at_boundary
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  // Step up/down, wrapping to the opposite bound when the boundary is hit
  always_comb begin
    next_count  = count;
    at_boundary = 1'b0;
    if (updown) begin
      if (count == MAX_C) begin
        at_boundary = 1'b1;
        next_count  = '0;
      end else begin
        next_count = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        at_boundary = 1'b1;
        next_count  = MAX_C;
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

endmodule : udc_step

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with bounded range, synchronous load,
// start/stop FSM and free-run / one-shot modes.
// Build option: define UDC_SATURATE_EN to make free-run mode saturate at the
// bounds (count held, tc asserted on every attempted boundary step) instead
// of wrapping.
module param_updown_counter
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             updown,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      EXT_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

  udc_state_t       state;
  udc_state_t       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;
  logic [WIDTH-1:0] load_clip;

  udc_step #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL)
  ) u_step (
    .count      (count),
    .updown     (updown),
    .next_count (step_count),
    .at_boundary(step_boundary)
  );

  // Clip load value to the top of the range (compared one bit wider so a
  // full-range MAX_VAL does not collapse into a constant comparison)
  always_comb begin
    load_clip = load_val;
    if ({1'b0, load_val} > EXT_W'(MAX_VAL)) begin
      load_clip = MAX_C;
    end
  end

  // Next state, next count and terminal-count pulse; stop in RUN suppresses
  // the step on the same edge, and load overrides any count update
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    unique case (state)
      UDC_IDLE: begin
        if (start && !stop) begin
          state_nxt = UDC_RUN;
        end
      end
      UDC_RUN: begin
        if (stop) begin
          state_nxt = UDC_IDLE;
        end else if (en && !load) begin
          if (!step_boundary) begin
            count_nxt = step_count;
          end else if (oneshot) begin
            tc_nxt    = 1'b1;
            state_nxt = UDC_DONE;
          end else begin
            tc_nxt = 1'b1;
`ifdef UDC_SATURATE_EN
            count_nxt = count;
`else
            count_nxt = step_count;
`endif
          end
        end
      end
      UDC_DONE: begin
        if (stop) begin
          state_nxt = UDC_IDLE;
        end else if (start) begin
          state_nxt = UDC_RUN;
          count_nxt = RST_C;
        end
      end
      default: begin
        state_nxt = UDC_IDLE;
      end
    endcase
    if (load) begin
      count_nxt = load_clip;
    end
  end

  // State, count and tc registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= UDC_IDLE;
      count <= RST_C;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  assign busy = (state == UDC_RUN);
  assign done = (state == UDC_DONE);

endmodule : param_updown_counter
